// File: rtl/ps2_pkg.sv
// Shared constants and FSM state encoding for the PS/2 line conditioner.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RECEIVE  = 2'd1,
        ST_COMPLETE = 2'd2
    } ps2_state_t;

    localparam int FRAME_BITS              = 11;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 5000;

endpackage

// File: rtl/line_debouncer.sv
// Two-flop synchronizer followed by a run-length debounce filter for one PS/2 line.
module line_debouncer #(
    parameter int DEBOUNCE_CYCLES = ps2_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic FCLK,
    input  logic RESET,
    input  logic line_raw,
    output logic line_filtered
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] stable_count;

    always_ff @(posedge FCLK or posedge RESET) begin
        if (RESET) begin
            sync_1        <= 1'b1;
            sync_2        <= 1'b1;
            line_filtered <= 1'b1;
            stable_count  <= '0;
        end else begin
            sync_1 <= line_raw;
            sync_2 <= sync_1;
            // Any sample agreeing with the filtered value restarts the run.
            if (sync_2 == line_filtered) begin
                stable_count <= '0;
            end else if (stable_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                line_filtered <= sync_2;
                stable_count  <= '0;
            end else begin
                stable_count <= stable_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_line_conditioner.sv
// PS/2 receive front end: filters both lines, pulses on clock falling edges and frames bits.
//
// state       | meaning
// ST_IDLE     | waiting for a falling edge with data low (start bit)
// ST_RECEIVE  | counting bits; idle timer running between edges
// ST_COMPLETE | one cycle: report stop bit as confirm or error, then idle
module ps2_line_conditioner #(
    parameter int DEBOUNCE_CYCLES = ps2_pkg::DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = ps2_pkg::DEFAULT_TIMEOUT_CYCLES,
    parameter int FRAME_BITS      = ps2_pkg::FRAME_BITS
) (
    input  logic       FCLK,
    input  logic       RESET,
    input  logic       ps2ClockRaw,
    input  logic       ps2DataRaw,
    output logic       controlClock,
    output logic       debouncedData,
    output logic       confirmSendData,
    output logic       frameError,
    output logic       frameTimeout,
    output logic [3:0] bitCount
);

    import ps2_pkg::*;

    localparam int         TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic               clock_filtered;
    logic               clock_prev;
    logic               falling_edge;
    logic               timer_expired;
    logic               stop_bit;
    logic [TIMER_W-1:0] idle_timer;
    ps2_state_t         state;

    line_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clock_debouncer (
        .FCLK          (FCLK),
        .RESET         (RESET),
        .line_raw      (ps2ClockRaw),
        .line_filtered (clock_filtered)
    );

    line_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_data_debouncer (
        .FCLK          (FCLK),
        .RESET         (RESET),
        .line_raw      (ps2DataRaw),
        .line_filtered (debouncedData)
    );

    assign falling_edge  = clock_prev & ~clock_filtered;
    assign timer_expired = (state == ST_RECEIVE) &&
                           (idle_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge FCLK or posedge RESET) begin
        if (RESET) begin
            clock_prev   <= 1'b1;
            controlClock <= 1'b0;
        end else begin
            clock_prev   <= clock_filtered;
            controlClock <= falling_edge;
        end
    end

    // Saturating idle timer; only meaningful while a frame is in progress.
    always_ff @(posedge FCLK or posedge RESET) begin
        if (RESET) begin
            idle_timer <= '0;
        end else if (falling_edge || (state != ST_RECEIVE)) begin
            idle_timer <= '0;
        end else if (idle_timer != TIMER_W'(TIMEOUT_CYCLES)) begin
            idle_timer <= idle_timer + 1'b1;
        end
    end

    always_ff @(posedge FCLK or posedge RESET) begin
        if (RESET) begin
            state           <= ST_IDLE;
            bitCount        <= 4'd0;
            stop_bit        <= 1'b1;
            confirmSendData <= 1'b0;
            frameError      <= 1'b0;
            frameTimeout    <= 1'b0;
        end else begin
            confirmSendData <= 1'b0;
            frameError      <= 1'b0;
            frameTimeout    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (falling_edge) begin
                        if (!debouncedData) begin
                            state    <= ST_RECEIVE;
                            bitCount <= 4'd1;
                        end else begin
                            bitCount <= 4'd0;
                        end
                    end
                end
                ST_RECEIVE: begin
                    // An edge always beats a simultaneous timeout.
                    if (falling_edge) begin
                        if (bitCount == LAST_BIT) begin
                            stop_bit <= debouncedData;
                            state    <= ST_COMPLETE;
                        end else begin
                            bitCount <= bitCount + 4'd1;
                        end
                    end else if (timer_expired) begin
                        frameTimeout <= 1'b1;
                        bitCount     <= 4'd0;
                        state        <= ST_IDLE;
                    end
                end
                ST_COMPLETE: begin
                    confirmSendData <= stop_bit;
                    frameError      <= ~stop_bit;
                    bitCount        <= 4'd0;
                    state           <= ST_IDLE;
                end
                default: begin
                    bitCount <= 4'd0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_line_conditioner.md
PS2_LINE_CONDITIONER -- requirements
Module: ps2_line_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 8: consecutive equal synchronized samples required before a filtered line changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000: idle FCLK cycles mid-frame before the frame is abandoned.
REQ-003 SHALL have parameter FRAME_BITS, default 11: bits per frame (start, 8 data LSB-first, parity, stop).
REQ-004 SHALL use one clock: FCLK  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL use reset: RESET  input  1  asynchronous, active-high reset.
REQ-006 ps2ClockRaw  input  1  raw PS/2 clock line, asynchronous to FCLK.
REQ-007 ps2DataRaw  input  1  raw PS/2 data line, asynchronous to FCLK.
REQ-008 controlClock  output  1  one-FCLK-cycle pulse per accepted falling edge of the filtered PS/2 clock.
REQ-009 debouncedData  output  1  filtered PS/2 data line.
REQ-010 confirmSendData  output  1  one-cycle strobe: valid frame completed.
REQ-011 frameError  output  1  one-cycle strobe: stop bit was 0.
REQ-012 frameTimeout  output  1  one-cycle strobe: frame abandoned on timeout.
REQ-013 bitCount  output  4  bits received in the current frame, 0..FRAME_BITS-1.

Function
REQ-014 Each raw line SHALL pass through a 2-flop synchronizer, then a debounce counter; the filtered value changes only after DEBOUNCE_CYCLES consecutive samples differing from it, and the counter clears on any sample equal to it.
REQ-015 A raw transition held stable SHALL appear on the filtered line exactly 2+DEBOUNCE_CYCLES FCLK cycles later; pulses shorter than DEBOUNCE_CYCLES cycles SHALL be rejected.
REQ-016 controlClock SHALL pulse high the cycle after the filtered clock goes 1->0; never on 0->1.
REQ-017 FSM states IDLE, RECEIVE, COMPLETE.
REQ-018 IDLE: on a falling edge with debouncedData=0 (start bit) go to RECEIVE, bitCount=1; with debouncedData=1 stay in IDLE, bitCount=0.
REQ-019 RECEIVE: each falling edge increments bitCount; on the edge where bitCount=FRAME_BITS-1 go to COMPLETE.
REQ-020 COMPLETE (one cycle): pulse confirmSendData if stop bit sampled 1, else frameError; bitCount=0; return to IDLE.
REQ-021 Strobes SHALL be exactly one cycle wide, and confirmSendData and frameError SHALL be mutually exclusive.
REQ-022 Timeout counter SHALL clear on every falling edge and count in RECEIVE; on reaching TIMEOUT_CYCLES it SHALL pulse frameTimeout, clear bitCount and go to IDLE.
REQ-023 A timeout and an edge in the same cycle: the edge wins and no frameTimeout pulse is issued.
REQ-024 Timeout counter width SHALL be clog2(TIMEOUT_CYCLES+1); it SHALL saturate, never wrap.

Reset
REQ-025 RESET SHALL asynchronously force: synchronizers and filtered lines 1, debouncedData 1, controlClock 0, all strobes 0, bitCount 0, counters 0, state IDLE.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first complete frame after release SHALL be accepted normally.

Structure
REQ-027 Package ps2_pkg SHALL hold the FSM state enum, FRAME_BITS, and the default DEBOUNCE_CYCLES/TIMEOUT_CYCLES constants.
REQ-028 Sub-module line_debouncer (synchronizer plus debounce counter, DEBOUNCE_CYCLES parameter) SHALL be instantiated twice, once per line.

Verification
REQ-029 Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1, each bit 50 cycles per phase) -> 11 controlClock pulses, then one confirmSendData, no frameError, bitCount back to 0.
REQ-030 Raw clock low glitch of 3 cycles, DEBOUNCE_CYCLES=8 -> no controlClock pulse, bitCount unchanged.
REQ-031 Valid 10 bits then stop bit 0 -> one frameError, no confirmSendData, state IDLE.
REQ-032 5 bits then clock idle -> frameTimeout exactly TIMEOUT_CYCLES cycles after the 5th controlClock, bitCount 0; next full frame confirmed.
REQ-033 RESET pulse after 6 bits -> all outputs at reset values immediately; following frame 0x1C confirmed.
REQ-034 Falling edge with data 1 in IDLE -> controlClock pulses, bitCount stays 0, no strobes.
